spartan_upsize: RTL and testbench
=================================

Name: spartan_upsize

Overview:
- Far-side partner of spartan_downsize. Restores a half-width Spartan link to full width.
- Master path: consumes two half beats (low half first) and emits one full master word.
- Slave path: takes full slave words and serializes each into two half beats for the return link.
- Datapaths are built in-module (gearbox plus holding registers); no reduce/expand instances.

Parameters:
- BWIDTH, 64, full-bus data width. The full bus is BWIDTH+2 bits and the half bus is (BWIDTH/2)+1 bits. BWIDTH must be even.
- HW (localparam), (BWIDTH+2)/2, half-beat width.

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  synchronous, active-low reset
- SpMBUS_HALF  in  HW  master half beat from the link
- SpMVLD_HALF  in  1  master half beat valid
- SpMRDY_HALF  out  1  master half beat ready
- SpMBUS_FULL  out  BWIDTH+2  reassembled master word
- SpMVLD_FULL  out  1  master word valid
- SpMRDY_FULL  in  1  master word ready
- SpSBUS_FULL  in  BWIDTH+2  slave response word
- SpSVLD_FULL  in  1  slave word valid
- SpSRDY_FULL  out  1  slave word ready
- SpSBUS_HALF  out  HW  slave half beat to the link
- SpSVLD_HALF  out  1  slave half beat valid
- SpSRDY_HALF  in  1  slave half beat ready

Behaviour:
- Reset
  - RST_N is registered once to rst_n_q. All state clears on the edge after rst_n_q is sampled low, i.e. 2 edges after RST_N falls.
  - Reset values: SpMVLD_FULL=0, SpSVLD_HALF=0, SpMRDY_HALF=1, SpSRDY_FULL=1, SpMBUS_FULL=0, SpSBUS_HALF=0, both phases=LO.
  - Reset mid-word discards any partial half or partially sent word. No output beat is produced after the clear.
- Handshake
  - A transfer occurs when VLD&RDY are both high at a rising edge.
  - A valid output holds its data stable until accepted.
  - Every output is driven from flops or a mux of flops. Ready paths have no combinational valid->ready loop from the same side.
- Master expand FSM (state m_phase: LO, HI)
  - LO: SpMRDY_HALF=1. On accept, lo_reg<=SpMBUS_HALF and go to HI.
  - HI: SpMRDY_HALF = !SpMVLD_FULL | SpMRDY_FULL. On accept, SpMBUS_FULL<={SpMBUS_HALF, lo_reg}, SpMVLD_FULL<=1, go to LO.
  - SpMVLD_FULL clears when the word is accepted and no new high half completes in the same cycle.
  - Latency: full word is valid 1 cycle after the high half is accepted.
  - Throughput: one word per 2 half beats, no bubbles when SpMRDY_FULL=1.
- Slave reduce FSM (s_phase: LO, HI; hold register s_word, s_vld)
  - SpSRDY_FULL = !s_vld | (s_phase==HI & SpSRDY_HALF). This allows back-to-back words with no idle beat.
  - SpSVLD_HALF = s_vld.
  - SpSBUS_HALF = s_phase==LO ? s_word[HW-1:0] : s_word[2HW-1:HW].
  - Low accepted: go to HI.
  - High accepted: go to LO. If a new full word is accepted in the same cycle, load it and keep s_vld=1; otherwise s_vld<=0.
  - Latency: low half is valid 1 cycle after the full word is accepted.
- Simultaneous events
  - Master and slave paths are fully independent.
  - A full-side accept and a new half accept in the same cycle are both honoured.

Decomposition:
- Shared spartan package holds: spartan_full_w(BWIDTH)=BWIDTH+2, spartan_half_w(BWIDTH)=(BWIDTH+2)/2, and phase encoding PH_LO=0/PH_HI=1.
- One natural sub-module: spartan_gear2, a parameterised 2:1 serializer used for the slave path. The master path stays inline.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles -> from the 2nd edge SpMVLD_FULL=0, SpSVLD_HALF=0, SpMRDY_HALF=1, SpSRDY_FULL=1.
- Master expand, BWIDTH=64 (HW=33): halves 33'h0_1111_2222 then 33'h1_3333_4444, RDY_FULL=1 -> SpMBUS_FULL=66'h2_6666_8888_1111_2222, valid 1 cycle after the 2nd half.
- Master backpressure: word held with SpMRDY_FULL=0 -> next low half accepted, high half stalled (SpMRDY_HALF=0). Releasing RDY delivers both words in order with no loss.
- Slave reduce back-to-back: words A,B with SpSRDY_HALF=1 -> half beats A.lo, A.hi, B.lo, B.hi on consecutive cycles, SpSRDY_FULL high in A.hi cycle.
- Slave stall: SpSRDY_HALF toggling 1,0,1 -> SpSBUS_HALF stable while stalled, exactly 2 beats per word.
- Reset mid-word: assert RST_N=0 after one master low half -> subsequent high half pairs as new LO; no stale word emitted.
- Random loopback with spartan_downsize: 10k random words both directions, random ready -> bit-exact, in-order.

Source files
------------

// File: rtl/spartan_upsize_pkg.sv
// Shared Spartan link definitions: bus width helpers and gearbox phase encoding.
// The full bus always carries two extra sideband bits on top of BWIDTH data bits.
package spartan_upsize_pkg;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_e;

  function automatic int spartan_full_w(input int bwidth);
    return bwidth + 2;
  endfunction

  function automatic int spartan_half_w(input int bwidth);
    return (bwidth + 2) / 2;
  endfunction

endpackage

// File: rtl/spartan_upsize_if.sv
// Spartan half/full link bundle. The slave modport is the upsizer's view,
// the master modport is the view of whoever drives the link and the full bus.
interface spartan_upsize_if
  import spartan_upsize_pkg::*;
#(
  parameter int BWIDTH = 64
);

  localparam int HW = spartan_half_w(BWIDTH);
  localparam int FW = spartan_full_w(BWIDTH);

  logic [HW-1:0] SpMBUS_HALF;
  logic          SpMVLD_HALF;
  logic          SpMRDY_HALF;
  logic [FW-1:0] SpMBUS_FULL;
  logic          SpMVLD_FULL;
  logic          SpMRDY_FULL;
  logic [FW-1:0] SpSBUS_FULL;
  logic          SpSVLD_FULL;
  logic          SpSRDY_FULL;
  logic [HW-1:0] SpSBUS_HALF;
  logic          SpSVLD_HALF;
  logic          SpSRDY_HALF;

  modport slave (
    input  SpMBUS_HALF, SpMVLD_HALF,
    output SpMRDY_HALF,
    output SpMBUS_FULL, SpMVLD_FULL,
    input  SpMRDY_FULL,
    input  SpSBUS_FULL, SpSVLD_FULL,
    output SpSRDY_FULL,
    output SpSBUS_HALF, SpSVLD_HALF,
    input  SpSRDY_HALF
  );

  modport master (
    output SpMBUS_HALF, SpMVLD_HALF,
    input  SpMRDY_HALF,
    input  SpMBUS_FULL, SpMVLD_FULL,
    output SpMRDY_FULL,
    output SpSBUS_FULL, SpSVLD_FULL,
    input  SpSRDY_FULL,
    input  SpSBUS_HALF, SpSVLD_HALF,
    output SpSRDY_HALF
  );

endinterface

// File: rtl/spartan_upsize_gear2.sv
// 2:1 serializer: holds one full word and emits it as low half then high half.
// A new word can be loaded in the same cycle the high half leaves, so there is no idle beat.
module spartan_upsize_gear2
  import spartan_upsize_pkg::*;
#(
  parameter int W = 33
) (
  input  logic           clk,
  input  logic           rst_n_q,
  input  logic [2*W-1:0] word,
  input  logic           word_vld,
  output logic           word_rdy,
  output logic [W-1:0]   half,
  output logic           half_vld,
  input  logic           half_rdy
);

  phase_e         s_phase, s_phase_nxt;
  logic [2*W-1:0] s_word, s_word_nxt;
  logic           s_vld, s_vld_nxt;
  logic           half_acc, word_acc;

  always_ff @(posedge clk) begin
    if (!rst_n_q) begin
      s_phase <= PH_LO;
      s_word  <= '0;
      s_vld   <= 1'b0;
    end else begin
      s_phase <= s_phase_nxt;
      s_word  <= s_word_nxt;
      s_vld   <= s_vld_nxt;
    end
  end

  always_comb begin
    s_phase_nxt = s_phase;
    s_word_nxt  = s_word;
    s_vld_nxt   = s_vld;
    // ready depends only on local state and the downstream ready, never on word_vld
    word_rdy    = !s_vld || (s_phase == PH_HI && half_rdy);
    half_acc    = s_vld && half_rdy;
    word_acc    = word_vld && word_rdy;

    if (half_acc)
      s_phase_nxt = (s_phase == PH_LO) ? PH_HI : PH_LO;

    if (word_acc) begin
      s_word_nxt = word;
      s_vld_nxt  = 1'b1;
    end else if (half_acc && s_phase == PH_HI) begin
      s_vld_nxt  = 1'b0;
    end
  end

  assign half_vld = s_vld;
  assign half     = (s_phase == PH_LO) ? s_word[W-1:0] : s_word[2*W-1:W];

endmodule

// File: rtl/spartan_upsize.sv
// Far side of the half-width Spartan link: pairs master half beats into full words
// and splits full slave responses back into half beats for the return link.
module spartan_upsize
  import spartan_upsize_pkg::*;
#(
  parameter int BWIDTH = 64
) (
  input  logic CLK,
  input  logic RST_N,
  spartan_upsize_if.slave bus
);

  localparam int HW = spartan_half_w(BWIDTH);
  localparam int FW = spartan_full_w(BWIDTH);

  logic rst_n_q;

  always_ff @(posedge CLK)
    rst_n_q <= RST_N;

  // ---------------- master expand ----------------
  phase_e        m_phase, m_phase_nxt;
  logic [HW-1:0] lo_reg, lo_reg_nxt;
  logic [FW-1:0] full_q, full_nxt;
  logic          full_vld, full_vld_nxt;
  logic          m_rdy, m_acc;

  always_ff @(posedge CLK) begin
    if (!rst_n_q) begin
      m_phase  <= PH_LO;
      lo_reg   <= '0;
      full_q   <= '0;
      full_vld <= 1'b0;
    end else begin
      m_phase  <= m_phase_nxt;
      lo_reg   <= lo_reg_nxt;
      full_q   <= full_nxt;
      full_vld <= full_vld_nxt;
    end
  end

  always_comb begin
    m_phase_nxt  = m_phase;
    lo_reg_nxt   = lo_reg;
    full_nxt     = full_q;
    full_vld_nxt = full_vld;
    // high half may only land when the output register is free or draining this cycle
    m_rdy        = (m_phase == PH_LO) || !full_vld || bus.SpMRDY_FULL;
    m_acc        = bus.SpMVLD_HALF && m_rdy;

    if (full_vld && bus.SpMRDY_FULL)
      full_vld_nxt = 1'b0;

    if (m_acc) begin
      if (m_phase == PH_LO) begin
        lo_reg_nxt  = bus.SpMBUS_HALF;
        m_phase_nxt = PH_HI;
      end else begin
        full_nxt     = {bus.SpMBUS_HALF, lo_reg};
        full_vld_nxt = 1'b1;
        m_phase_nxt  = PH_LO;
      end
    end
  end

  assign bus.SpMRDY_HALF = m_rdy;
  assign bus.SpMBUS_FULL = full_q;
  assign bus.SpMVLD_FULL = full_vld;

  // ---------------- slave reduce ----------------
  spartan_upsize_gear2 #(.W(HW)) u_gear2 (
    .clk      (CLK),
    .rst_n_q  (rst_n_q),
    .word     (bus.SpSBUS_FULL),
    .word_vld (bus.SpSVLD_FULL),
    .word_rdy (bus.SpSRDY_FULL),
    .half     (bus.SpSBUS_HALF),
    .half_vld (bus.SpSVLD_HALF),
    .half_rdy (bus.SpSRDY_HALF)
  );

endmodule

// File: tb/tb_spartan_upsize.sv
// Self-checking bench for spartan_upsize: directed scenarios plus a randomized
// run scored against word/half-beat queues.
module tb_spartan_upsize;
  import spartan_upsize_pkg::*;

  localparam int BW = 64;
  localparam int HW = spartan_half_w(BW);
  localparam int FW = spartan_full_w(BW);

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   checks = 0;
  int   errors = 0;

  spartan_upsize_if #(.BWIDTH(BW)) bus();

  spartan_upsize #(.BWIDTH(BW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [FW-1:0] rand_word();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[FW-1:0];
  endfunction

  task automatic idle();
    bus.SpMVLD_HALF = 1'b0;
    bus.SpMBUS_HALF = '0;
    bus.SpMRDY_FULL = 1'b1;
    bus.SpSVLD_FULL = 1'b0;
    bus.SpSBUS_FULL = '0;
    bus.SpSRDY_HALF = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (bus.SpMVLD_FULL !== 1'b0) begin errors++; $display("FAIL reset_mvld_full: got %0b want 0", bus.SpMVLD_FULL); end
    checks++; if (bus.SpSVLD_HALF !== 1'b0) begin errors++; $display("FAIL reset_svld_half: got %0b want 0", bus.SpSVLD_HALF); end
    checks++; if (bus.SpMRDY_HALF !== 1'b1) begin errors++; $display("FAIL reset_mrdy_half: got %0b want 1", bus.SpMRDY_HALF); end
    checks++; if (bus.SpSRDY_FULL !== 1'b1) begin errors++; $display("FAIL reset_srdy_full: got %0b want 1", bus.SpSRDY_FULL); end
    checks++; if (bus.SpMBUS_FULL !== '0) begin errors++; $display("FAIL reset_mbus_full: got %h want 0", bus.SpMBUS_FULL); end
    checks++; if (bus.SpSBUS_HALF !== '0) begin errors++; $display("FAIL reset_sbus_half: got %h want 0", bus.SpSBUS_HALF); end
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (bus.SpMVLD_FULL !== 1'b0 || bus.SpSVLD_HALF !== 1'b0) begin errors++; $display("FAIL reset_release_vld: got %0b/%0b want 0/0", bus.SpMVLD_FULL, bus.SpSVLD_HALF); end
  endtask

  task automatic test_master_expand();
    logic [HW-1:0] lo, hi;
    logic [FW-1:0] exp;
    lo  = 33'h0_1111_2222;
    hi  = 33'h1_3333_4444;
    exp = (FW'(hi) << HW) | FW'(lo);
    @(negedge CLK);
    bus.SpMRDY_FULL = 1'b1;
    bus.SpMVLD_HALF = 1'b1;
    bus.SpMBUS_HALF = lo;
    @(posedge CLK);
    @(negedge CLK);
    bus.SpMBUS_HALF = hi;
    checks++; if (bus.SpMVLD_FULL !== 1'b0) begin errors++; $display("FAIL expand_early_vld: got %0b want 0", bus.SpMVLD_FULL); end
    @(posedge CLK);
    @(negedge CLK);
    bus.SpMVLD_HALF = 1'b0;
    checks++; if (bus.SpMVLD_FULL !== 1'b1) begin errors++; $display("FAIL expand_vld: got %0b want 1", bus.SpMVLD_FULL); end
    checks++; if (bus.SpMBUS_FULL !== exp) begin errors++; $display("FAIL expand_word: got %h want %h", bus.SpMBUS_FULL, exp); end
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (bus.SpMVLD_FULL !== 1'b0) begin errors++; $display("FAIL expand_vld_clear: got %0b want 0", bus.SpMVLD_FULL); end
  endtask

  task automatic test_master_backpressure();
    logic [FW-1:0] w1, w2;
    w1 = rand_word();
    w2 = rand_word();
    @(negedge CLK);
    bus.SpMRDY_FULL = 1'b0;
    bus.SpMVLD_HALF = 1'b1;
    bus.SpMBUS_HALF = w1[HW-1:0];
    @(posedge CLK);
    @(negedge CLK);
    bus.SpMBUS_HALF = w1[FW-1:HW];
    @(posedge CLK);
    @(negedge CLK);
    bus.SpMBUS_HALF = w2[HW-1:0];
    #1;
    checks++; if (bus.SpMRDY_HALF !== 1'b1) begin errors++; $display("FAIL bp_lo_rdy: got %0b want 1", bus.SpMRDY_HALF); end
    checks++; if (bus.SpMVLD_FULL !== 1'b1 || bus.SpMBUS_FULL !== w1) begin errors++; $display("FAIL bp_w1_held: got %0b/%h want 1/%h", bus.SpMVLD_FULL, bus.SpMBUS_FULL, w1); end
    @(posedge CLK);
    @(negedge CLK);
    bus.SpMBUS_HALF = w2[FW-1:HW];
    #1;
    checks++; if (bus.SpMRDY_HALF !== 1'b0) begin errors++; $display("FAIL bp_hi_stall: got %0b want 0", bus.SpMRDY_HALF); end
    @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++; if (bus.SpMRDY_HALF !== 1'b0 || bus.SpMBUS_FULL !== w1) begin errors++; $display("FAIL bp_stall_stable: got %0b/%h want 0/%h", bus.SpMRDY_HALF, bus.SpMBUS_FULL, w1); end
    bus.SpMRDY_FULL = 1'b1;
    #1;
    checks++; if (bus.SpMRDY_HALF !== 1'b1) begin errors++; $display("FAIL bp_release_rdy: got %0b want 1", bus.SpMRDY_HALF); end
    @(posedge CLK);
    @(negedge CLK);
    bus.SpMVLD_HALF = 1'b0;
    checks++; if (bus.SpMVLD_FULL !== 1'b1 || bus.SpMBUS_FULL !== w2) begin errors++; $display("FAIL bp_w2: got %0b/%h want 1/%h", bus.SpMVLD_FULL, bus.SpMBUS_FULL, w2); end
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (bus.SpMVLD_FULL !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b want 0", bus.SpMVLD_FULL); end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] a, b;
    a = rand_word();
    b = rand_word();
    @(negedge CLK);
    bus.SpSRDY_HALF = 1'b1;
    bus.SpSVLD_FULL = 1'b1;
    bus.SpSBUS_FULL = a;
    #1;
    checks++; if (bus.SpSRDY_FULL !== 1'b1) begin errors++; $display("FAIL b2b_idle_rdy: got %0b want 1", bus.SpSRDY_FULL); end
    @(posedge CLK);
    @(negedge CLK);
    bus.SpSBUS_FULL = b;
    #1;
    checks++; if (bus.SpSVLD_HALF !== 1'b1 || bus.SpSBUS_HALF !== a[HW-1:0]) begin errors++; $display("FAIL b2b_a_lo: got %0b/%h want 1/%h", bus.SpSVLD_HALF, bus.SpSBUS_HALF, a[HW-1:0]); end
    checks++; if (bus.SpSRDY_FULL !== 1'b0) begin errors++; $display("FAIL b2b_lo_rdy: got %0b want 0", bus.SpSRDY_FULL); end
    @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++; if (bus.SpSBUS_HALF !== a[FW-1:HW]) begin errors++; $display("FAIL b2b_a_hi: got %h want %h", bus.SpSBUS_HALF, a[FW-1:HW]); end
    checks++; if (bus.SpSRDY_FULL !== 1'b1) begin errors++; $display("FAIL b2b_hi_rdy: got %0b want 1", bus.SpSRDY_FULL); end
    @(posedge CLK);
    @(negedge CLK);
    bus.SpSVLD_FULL = 1'b0;
    #1;
    checks++; if (bus.SpSVLD_HALF !== 1'b1 || bus.SpSBUS_HALF !== b[HW-1:0]) begin errors++; $display("FAIL b2b_b_lo: got %0b/%h want 1/%h", bus.SpSVLD_HALF, bus.SpSBUS_HALF, b[HW-1:0]); end
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (bus.SpSVLD_HALF !== 1'b1 || bus.SpSBUS_HALF !== b[FW-1:HW]) begin errors++; $display("FAIL b2b_b_hi: got %0b/%h want 1/%h", bus.SpSVLD_HALF, bus.SpSBUS_HALF, b[FW-1:HW]); end
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (bus.SpSVLD_HALF !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0b want 0", bus.SpSVLD_HALF); end
  endtask

  task automatic test_slave_stall();
    logic [FW-1:0] c;
    logic [HW-1:0] exp_h;
    logic          pat [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int            beats;
    c = rand_word();
    beats = 0;
    @(negedge CLK);
    bus.SpSRDY_HALF = 1'b0;
    bus.SpSVLD_FULL = 1'b1;
    bus.SpSBUS_FULL = c;
    @(posedge CLK);
    @(negedge CLK);
    bus.SpSVLD_FULL = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.SpSRDY_HALF = pat[i];
      #1;
      if (bus.SpSVLD_HALF) begin
        exp_h = (beats == 0) ? c[HW-1:0] : c[FW-1:HW];
        checks++; if (bus.SpSBUS_HALF !== exp_h) begin errors++; $display("FAIL stall_half%0d: got %h want %h", i, bus.SpSBUS_HALF, exp_h); end
        if (pat[i]) beats++;
      end
      @(posedge CLK);
      @(negedge CLK);
    end
    checks++; if (beats !== 2) begin errors++; $display("FAIL stall_beats: got %0d want 2", beats); end
    checks++; if (bus.SpSVLD_HALF !== 1'b0) begin errors++; $display("FAIL stall_drain: got %0b want 0", bus.SpSVLD_HALF); end
    bus.SpSRDY_HALF = 1'b1;
  endtask

  task automatic test_reset_midword();
    logic [HW-1:0] x, y;
    logic [FW-1:0] exp;
    x = HW'({$urandom, $urandom});
    y = HW'({$urandom, $urandom});
    exp = (FW'(y) << HW) | FW'(x);
    @(negedge CLK);
    bus.SpMRDY_FULL = 1'b1;
    bus.SpMVLD_HALF = 1'b1;
    bus.SpMBUS_HALF = ~x;
    bus.SpSRDY_HALF = 1'b0;
    bus.SpSVLD_FULL = 1'b1;
    bus.SpSBUS_FULL = rand_word();
    @(posedge CLK);
    @(negedge CLK);
    bus.SpMVLD_HALF = 1'b0;
    bus.SpSVLD_FULL = 1'b0;
    bus.SpSRDY_HALF = 1'b1;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (bus.SpMVLD_FULL !== 1'b0 || bus.SpSVLD_HALF !== 1'b0) begin errors++; $display("FAIL midrst_clear: got %0b/%0b want 0/0", bus.SpMVLD_FULL, bus.SpSVLD_HALF); end
    RST_N = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.SpMVLD_HALF = 1'b1;
    bus.SpMBUS_HALF = x;
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (bus.SpMVLD_FULL !== 1'b0 || bus.SpSVLD_HALF !== 1'b0) begin errors++; $display("FAIL midrst_no_stale: got %0b/%0b want 0/0", bus.SpMVLD_FULL, bus.SpSVLD_HALF); end
    bus.SpMBUS_HALF = y;
    @(posedge CLK);
    @(negedge CLK);
    bus.SpMVLD_HALF = 1'b0;
    checks++; if (bus.SpMVLD_FULL !== 1'b1 || bus.SpMBUS_FULL !== exp) begin errors++; $display("FAIL midrst_pair: got %0b/%h want 1/%h", bus.SpMVLD_FULL, bus.SpMBUS_FULL, exp); end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_random();
    localparam int N = 400;
    logic [FW-1:0] m_src[$];
    logic [FW-1:0] m_exp[$];
    logic [HW-1:0] s_exp[$];
    logic [FW-1:0] w, s_cur, prev_full, got_w;
    logic [HW-1:0] prev_half;
    logic          m_on, s_on, mh, m_held, s_held;
    int            mi, si, m_got, s_got, cyc;
    for (int i = 0; i < N; i++) m_src.push_back(rand_word());
    m_exp = m_src;
    m_on = 0; s_on = 0; mh = 0; m_held = 0; s_held = 0;
    mi = 0; si = 0; m_got = 0; s_got = 0; cyc = 0;
    s_cur = '0;
    while ((m_got < N || s_got < 2*N) && cyc < 20000) begin
      @(negedge CLK);
      cyc++;
      if (!m_on && mi < N && $urandom_range(3) != 0) m_on = 1;
      w = (mi < N) ? m_src[mi] : '0;
      bus.SpMVLD_HALF = m_on;
      bus.SpMBUS_HALF = mh ? w[FW-1:HW] : w[HW-1:0];
      bus.SpMRDY_FULL = 1'($urandom_range(1));
      if (!s_on && si < N && $urandom_range(3) != 0) begin s_on = 1; s_cur = rand_word(); end
      bus.SpSVLD_FULL = s_on;
      bus.SpSBUS_FULL = s_cur;
      bus.SpSRDY_HALF = 1'($urandom_range(1));
      #1;
      if (m_held) begin
        checks++; if (bus.SpMVLD_FULL !== 1'b1 || bus.SpMBUS_FULL !== prev_full) begin errors++; $display("FAIL rnd_mfull_stable: got %0b/%h want 1/%h", bus.SpMVLD_FULL, bus.SpMBUS_FULL, prev_full); end
      end
      if (s_held) begin
        checks++; if (bus.SpSVLD_HALF !== 1'b1 || bus.SpSBUS_HALF !== prev_half) begin errors++; $display("FAIL rnd_shalf_stable: got %0b/%h want 1/%h", bus.SpSVLD_HALF, bus.SpSBUS_HALF, prev_half); end
      end
      if (bus.SpMVLD_HALF && bus.SpMRDY_HALF) begin
        m_on = 0;
        if (mh) begin mh = 0; mi++; end else mh = 1;
      end
      if (bus.SpMVLD_FULL && bus.SpMRDY_FULL) begin
        checks++;
        if (m_exp.size() == 0) begin errors++; $display("FAIL rnd_m_extra: got %h want none", bus.SpMBUS_FULL); end
        else begin
          got_w = m_exp.pop_front();
          if (bus.SpMBUS_FULL !== got_w) begin errors++; $display("FAIL rnd_m_word%0d: got %h want %h", m_got, bus.SpMBUS_FULL, got_w); end
        end
        m_got++;
      end
      if (bus.SpSVLD_FULL && bus.SpSRDY_FULL) begin
        s_on = 0;
        s_exp.push_back(s_cur[HW-1:0]);
        s_exp.push_back(s_cur[FW-1:HW]);
        si++;
      end
      if (bus.SpSVLD_HALF && bus.SpSRDY_HALF) begin
        checks++;
        if (s_exp.size() == 0) begin errors++; $display("FAIL rnd_s_extra: got %h want none", bus.SpSBUS_HALF); end
        else begin
          prev_half = s_exp.pop_front();
          if (bus.SpSBUS_HALF !== prev_half) begin errors++; $display("FAIL rnd_s_half%0d: got %h want %h", s_got, bus.SpSBUS_HALF, prev_half); end
        end
        s_got++;
      end
      m_held    = bus.SpMVLD_FULL && !bus.SpMRDY_FULL;
      prev_full = bus.SpMBUS_FULL;
      s_held    = bus.SpSVLD_HALF && !bus.SpSRDY_HALF;
      prev_half = bus.SpSBUS_HALF;
    end
    checks++; if (m_got != N || s_got != 2*N) begin errors++; $display("FAIL rnd_timeout: got %0d/%0d want %0d/%0d", m_got, s_got, N, 2*N); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_master_expand();
    test_master_backpressure();
    test_back_to_back();
    test_slave_stall();
    test_reset_midword();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
